// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit framing stage.
package uart_tx_pkg;

  // Framing FSM states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Byte request / serial line bundle between the requester and the framing stage.
interface uart_tx_frame_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  Par_Bit;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, Par_Bit,
    input  TX_OUT, BUSY
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, Par_Bit,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Shift register plus bit counter for the data portion of a UART frame.
// ser_bit is always the next data bit to go out; ser_done rises once all
// DATA_WIDTH bits have been shifted out of the register.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_bit,
  output logic                  ser_done
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_r;
  logic [CW-1:0]         cnt_r;

  // Load, shift-right or clear the bit count; the counter stops at DATA_WIDTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_r <= {DATA_WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (load) begin
      shift_r <= load_data;
      cnt_r   <= {CW{1'b0}};
    end else if (shift_en) begin
      shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
      cnt_r   <= cnt_r + CW'(1);
    end else if (clear) begin
      cnt_r   <= {CW{1'b0}};
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  assign ser_bit  = shift_r[0];
  assign ser_done = (cnt_r == CW'(DATA_WIDTH));
endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framing stage: start bit, LSB-first data, optional parity,
// stop bit. One bit per CLK. TX_OUT and BUSY are registered; BUSY tells the
// parity calculator to stop capturing once a byte has been accepted.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_frame_ctrl_if.slave   bus
);
  tx_state_e state_r, next_state_s;
  logic      tx_r, tx_next_s;
  logic      busy_r, busy_next_s;
  logic      par_en_r, par_en_next_s;
  logic      load_s, shift_s, clear_s;
  logic      ser_bit_s, ser_done_s;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load_s),
    .shift_en  (shift_s),
    .clear     (clear_s),
    .load_data (bus.P_DATA),
    .ser_bit   (ser_bit_s),
    .ser_done  (ser_done_s)
  );

  // Next-state, next line level and serializer controls for each frame phase.
  always_comb begin
    next_state_s  = state_r;
    tx_next_s     = tx_r;
    busy_next_s   = busy_r;
    par_en_next_s = par_en_r;
    load_s        = 1'b0;
    shift_s       = 1'b0;
    clear_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Data_Valid) begin
          load_s        = 1'b1;
          par_en_next_s = bus.PAR_EN;
          tx_next_s     = START_BIT;
          busy_next_s   = 1'b1;
          next_state_s  = START;
        end else begin
          tx_next_s     = IDLE_LEVEL;
          busy_next_s   = 1'b0;
        end
      end
      START: begin
        tx_next_s    = ser_bit_s;
        shift_s      = 1'b1;
        next_state_s = DATA;
      end
      DATA: begin
        if (!ser_done_s) begin
          tx_next_s    = ser_bit_s;
          shift_s      = 1'b1;
        end else if (par_en_r) begin
          // Par_Bit was registered by the calculator long before this edge.
          tx_next_s    = bus.Par_Bit;
          next_state_s = PARITY;
        end else begin
          tx_next_s    = STOP_BIT;
          next_state_s = STOP;
        end
      end
      PARITY: begin
        tx_next_s    = STOP_BIT;
        next_state_s = STOP;
      end
      STOP: begin
        tx_next_s    = IDLE_LEVEL;
        busy_next_s  = 1'b0;
        clear_s      = 1'b1;
        next_state_s = IDLE;
      end
      default: begin
        tx_next_s    = IDLE_LEVEL;
        busy_next_s  = 1'b0;
        clear_s      = 1'b1;
        next_state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      tx_r     <= IDLE_LEVEL;
      busy_r   <= 1'b0;
      par_en_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      tx_r     <= tx_next_s;
      busy_r   <= busy_next_s;
      par_en_r <= par_en_next_s;
    end
  end

  assign bus.TX_OUT = tx_r;
  assign bus.BUSY   = busy_r;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl. A frame-level model turns each
// accepted byte into its list of line bits and plays that list out, one bit
// per clock; TX_OUT and BUSY are compared against it every cycle.
module tb_uart_tx_frame_ctrl;
  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          m_q[$];
  bit          m_tx    = 1'b1;
  bit          m_busy  = 1'b0;
  bit          par_odd = 1'b0;
  logic [31:0] cap     = 32'd0;
  int          bc;
  int          zeros;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: update the frame model from the inputs seen at the edge,
  // then compare the line and BUSY just after the edge.
  task automatic tick();
    bit acc;
    bit pb;
    @(posedge CLK);
    acc = 1'b0;
    pb  = 1'b0;
    if (RST) begin
      m_q.delete();
    end else if (!m_busy && bus.Data_Valid) begin
      acc = 1'b1;
      pb  = (^bus.P_DATA) ^ par_odd;
      m_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) m_q.push_back(bus.P_DATA[i]);
      if (bus.PAR_EN) m_q.push_back(pb);
      m_q.push_back(1'b1);
    end
    if (m_q.size() > 0) begin
      m_tx   = m_q.pop_front();
      m_busy = 1'b1;
    end else begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end
    #1;
    if (acc) bus.Par_Bit = pb;
    chk("tx", {31'd0, bus.TX_OUT}, {31'd0, m_tx});
    chk("busy", {31'd0, bus.BUSY}, {31'd0, m_busy});
    cap = {cap[30:0], bus.TX_OUT};
  endtask

  initial begin
    RST            = 1'b1;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.Par_Bit    = 1'b0;
    #2;
    tick();
    tick();
    RST = 1'b0;
    repeat (20) tick();

    // Parity frame 0xA5 with even parity -> Par_Bit 0.
    par_odd = 1'b0;
    bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.Data_Valid = 1'b1;
    cap = 32'd0; bc = 0;
    tick(); bc += int'(bus.BUSY);
    bus.Data_Valid = 1'b0;
    repeat (12) begin tick(); bc += int'(bus.BUSY); end
    chk("a5_seq", {19'd0, cap[12:0]}, {19'd0, 13'b0101001010111});
    chk("a5_busy_len", bc, 32'd11);

    // Frame 0x3C without parity.
    bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.Data_Valid = 1'b1;
    cap = 32'd0; bc = 0;
    tick(); bc += int'(bus.BUSY);
    bus.Data_Valid = 1'b0;
    repeat (11) begin tick(); bc += int'(bus.BUSY); end
    chk("3c_seq", {20'd0, cap[11:0]}, {20'd0, 12'b000111100111});
    chk("3c_busy_len", bc, 32'd10);

    // Requests while busy are dropped.
    bus.P_DATA = 8'hFF; bus.PAR_EN = 1'b1; bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      bus.Data_Valid = (k == 3 || k == 10);
      bus.P_DATA     = (k == 3 || k == 10) ? 8'h00 : 8'hFF;
      tick();
    end
    bus.Data_Valid = 1'b0;
    chk("rej_idle_tx", {31'd0, bus.TX_OUT}, 32'd1);

    // Back-to-back with Data_Valid held high.
    bus.P_DATA = 8'h81; bus.PAR_EN = 1'b1; bus.Data_Valid = 1'b1;
    tick();
    bus.P_DATA = 8'h7E;
    zeros = 0;
    repeat (12) begin tick(); zeros += int'(!bus.BUSY); end
    bus.Data_Valid = 1'b0;
    chk("b2b_gap", zeros, 32'd1);
    repeat (14) tick();

    // Reset during data bit 4; Data_Valid on the reset edge is discarded.
    bus.P_DATA = 8'h55; bus.PAR_EN = 1'b1; bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    repeat (5) tick();
    RST = 1'b1; bus.Data_Valid = 1'b1; bus.P_DATA = 8'hAA;
    tick();
    RST = 1'b0; bus.Data_Valid = 1'b0;
    chk("rst_tx", {31'd0, bus.TX_OUT}, 32'd1);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    repeat (3) tick();

    // PAR_EN toggled mid-frame must not change the frame length.
    bus.P_DATA = 8'h96; bus.PAR_EN = 1'b1; bus.Data_Valid = 1'b1;
    bc = 0;
    tick(); bc += int'(bus.BUSY);
    bus.Data_Valid = 1'b0;
    repeat (13) begin bus.PAR_EN = ~bus.PAR_EN; tick(); bc += int'(bus.BUSY); end
    chk("toggle_len", bc, 32'd11);

    // Randomised traffic, including rare resets and requests during frames.
    for (int c = 0; c < 2500; c++) begin
      bus.Data_Valid = ($urandom_range(0, 3) == 0);
      bus.P_DATA     = 8'($urandom);
      bus.PAR_EN     = 1'($urandom);
      if (!m_busy) par_odd = 1'($urandom);
      RST            = ($urandom_range(0, 149) == 0);
      tick();
    end
    RST = 1'b0; bus.Data_Valid = 1'b0;
    repeat (15) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- UART transmit framing stage: FSM plus serializer.
- Accepts a parallel byte on a Data_Valid strobe and drives the serial line: start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
- Drives BUSY back to the parity calculator, which uses it to gate its data capture.
- Consumes that calculator's registered Par_Bit during the parity slot.
- CLK is the bit-rate clock: one bit per CLK cycle.

Parameters:
- DATA_WIDTH, 8, width of P_DATA and the number of data bits per frame.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel byte to transmit.
- Data_Valid  input  1  one-cycle request; accepted only when BUSY=0.
- PAR_EN  input  1  parity slot enable; latched at acceptance.
- Par_Bit  input  1  parity bit from the parity calculator; sampled at entry to PARITY.
- TX_OUT  output  1  serial line; idle high.
- BUSY  output  1  high from the cycle after acceptance until the frame ends.

Behaviour:
- Reset: one clock, synchronous, active-high. On any edge with RST=1: state=IDLE, TX_OUT=1, BUSY=0, shift register=0, bit counter=0, latched PAR_EN=0. Reset overrides everything, including mid-frame; a partial frame is aborted with no completion.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - On an edge with Data_Valid=1: load the shift register with P_DATA, latch PAR_EN, go to START, TX_OUT<=0, BUSY<=1.
  - The parity calculator captures P_DATA on the same edge, because BUSY is still 0.
- START: one cycle. Next edge: TX_OUT<=shift[0], shift right, counter<=1, go to DATA.
- DATA: DATA_WIDTH cycles, bit i on TX_OUT during data cycle i.
  - While counter<DATA_WIDTH: TX_OUT<=shift[0], shift, counter+1.
  - When counter==DATA_WIDTH: if latched PAR_EN=1, TX_OUT<=Par_Bit and go to PARITY; else TX_OUT<=1 and go to STOP.
- PARITY: one cycle. Next edge: TX_OUT<=1, go to STOP.
- STOP: one cycle at TX_OUT=1. Next edge: go to IDLE, BUSY<=0, counter<=0.
- Frame length, from the first TX_OUT=0 cycle to the last stop cycle: DATA_WIDTH+3 with parity, DATA_WIDTH+2 without.
- Minimum Data_Valid-to-Data_Valid spacing: frame length + 1. At least one IDLE cycle separates frames.
- Data_Valid while BUSY=1 is ignored. Nothing is queued and no error is flagged.
- Par_Bit is stable by the sampling edge: the calculator registers it at least DATA_WIDTH cycles earlier.
- PAR_EN and the calculator's parity type must be held stable from acceptance to frame end. The block uses only its latched copy of PAR_EN, so a mid-frame PAR_EN change does not alter frame length.
- Counter width: $clog2(DATA_WIDTH+1). It must never wrap within a frame.
- Data_Valid on the same edge as RST=1 is discarded.

Decomposition:
- Shared package (uart_tx_pkg):
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
- Natural sub-module uart_tx_serializer:
  - load/shift enable in; ser_bit out; ser_done, asserted when DATA_WIDTH bits have been shifted.
  - Holds the shift register and bit counter.
- The FSM and the output mux stay in the top module.

Test Plan:
- Reset idle: RST=1 for 2 cycles, then 0 with Data_Valid=0 for 20 cycles -> TX_OUT=1, BUSY=0 throughout.
- Frame with parity: P_DATA=0xA5, PAR_EN=1, Par_Bit driven 0, Data_Valid for 1 cycle -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; BUSY high for exactly 11 cycles, starting the cycle after acceptance.
- Frame without parity: P_DATA=0x3C, PAR_EN=0 -> TX_OUT 0,0,0,1,1,1,1,0,0,1; 10 cycles; BUSY low on the next edge.
- Busy rejection: accept 0xFF; pulse Data_Valid with 0x00 at frame cycles 3 and 10 -> first frame transmitted unchanged; no second frame; TX_OUT=1 afterward.
- Back-to-back: Data_Valid=1 held continuously with 0x81 then 0x7E, PAR_EN=1 -> two complete frames; exactly one idle cycle (TX_OUT=1, BUSY=0) between the stop bit and the next start bit.
- Mid-frame reset and PAR_EN toggle:
  - Accept 0x55 and assert RST during data bit 4 -> next edge TX_OUT=1, BUSY=0, state IDLE.
  - A new frame after reset is correct.
  - Toggling PAR_EN mid-frame does not change frame length.
